// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared widths, RAM depth and opcodes for the SAP-1 datapath
package sap_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RAM_DEPTH  = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/memoria_ram.sv
// rtl/memoria_ram.sv - program/data RAM with async read and sync write port
module memoria_ram
  import sap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];

  // Write port; contents survive reset so a program stays loaded across clr.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read of the word being written this cycle sees the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_sap.sv
// rtl/datapath_sap.sv - SAP-1 W-bus datapath: PC, MAR, RAM, IR, ACC, B, ALU, output register
module datapath_sap
  import sap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Ea,
  input  logic              Su,
  input  logic              Eu,
  input  logic              Lm_barra,
  input  logic              CE_barra,
  input  logic              Li_barra,
  input  logic              Ei_barra,
  input  logic              La_barra,
  input  logic              Lb_barra,
  input  logic              Lo_barra,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        ri,
  output logic [DATA_W-1:0] saida,
  output logic              halted,
  output logic              bus_err
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] bus;
  logic [4:0]        srcs;
  logic              multi_src;

  memoria_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clock(clock),
    .we   (prog_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(mar),
    .rdata(ram_rdata)
  );

  // Carry/borrow is discarded; the result wraps modulo 2**DATA_W.
  assign alu = Su ? (acc - b) : (acc + b);

  // More than one bit set means at least two drivers fight for the bus.
  assign srcs      = {Ep, ~CE_barra, ~Ei_barra, Ea, Eu};
  assign multi_src = |(srcs & (srcs - 5'd1));

  assign ri = ir[DATA_W-1 -: 4];

  // Bus mux: fixed priority so a contended cycle still has a defined value.
  always_comb begin
    bus = '0;
    if (Ep) begin
      bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
    end else if (!CE_barra) begin
      bus = ram_rdata;
    end else if (!Ei_barra) begin
      bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
    end else if (Ea) begin
      bus = acc;
    end else if (Eu) begin
      bus = alu;
    end
  end

  // Register file: every load samples the pre-edge bus; halt freezes loads and PC.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      acc     <= '0;
      b       <= '0;
      saida   <= '0;
      halted  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (multi_src) begin
        bus_err <= 1'b1;
      end
      if (!halted) begin
        if (Cp) begin
          pc <= pc + PC_ONE;
        end
        if (!Lm_barra) begin
          mar <= bus[ADDR_W-1:0];
        end
        if (!Li_barra) begin
          ir <= bus;
          if (bus[DATA_W-1 -: 4] == OP_HLT) begin
            halted <= 1'b1;
          end
        end
        if (!La_barra) begin
          acc <= bus;
        end
        if (!Lb_barra) begin
          b <= bus;
        end
        if (!Lo_barra) begin
          saida <= bus;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_sap.sv
// tb/tb_datapath_sap.sv - self-checking bench for datapath_sap
module tb_datapath_sap;

  logic       clock = 1'b0;
  logic       clr;
  logic       Cp, Ep, Ea, Su, Eu;
  logic       Lm_barra, CE_barra, Li_barra, Ei_barra, La_barra, Lb_barra, Lo_barra;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] ri;
  logic [7:0] saida;
  logic       halted;
  logic       bus_err;

  int checks   = 0;
  int failures = 0;

  datapath_sap dut (
    .clock    (clock),
    .clr      (clr),
    .Cp       (Cp),
    .Ep       (Ep),
    .Ea       (Ea),
    .Su       (Su),
    .Eu       (Eu),
    .Lm_barra (Lm_barra),
    .CE_barra (CE_barra),
    .Li_barra (Li_barra),
    .Ei_barra (Ei_barra),
    .La_barra (La_barra),
    .Lb_barra (Lb_barra),
    .Lo_barra (Lo_barra),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .ri       (ri),
    .saida    (saida),
    .halted   (halted),
    .bus_err  (bus_err)
  );

  always #5 clock = ~clock;

  task automatic idle();
    Cp = 0; Ep = 0; Ea = 0; Su = 0; Eu = 0;
    Lm_barra = 1; CE_barra = 1; Li_barra = 1; Ei_barra = 1;
    La_barra = 1; Lb_barra = 1; Lo_barra = 1;
    prog_we = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic pulse_clr();
    #2 clr = 1;
    #2 clr = 0;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
  endtask

  // sel: 0 ACC, 1 B, 2 saida, 3 MAR; value goes through RAM at the current MAR
  task automatic load_via_ram(input logic [3:0] cur_mar, input logic [7:0] v, input int sel);
    prog_write(cur_mar, v);
    CE_barra = 0;
    case (sel)
      0: La_barra = 0;
      1: Lb_barra = 0;
      2: Lo_barra = 0;
      default: Lm_barra = 0;
    endcase
    tick();
  endtask

  // Plays the T1..T6 controller for one instruction.
  task automatic run_instr();
    logic [3:0] op;
    Ep = 1; Lm_barra = 0; tick();
    Cp = 1; tick();
    CE_barra = 0; Li_barra = 0; tick();
    op = ri;
    if (op == 4'h0) begin
      Ei_barra = 0; Lm_barra = 0; tick();
      CE_barra = 0; La_barra = 0; tick();
      tick();
    end else if (op == 4'h1 || op == 4'h2) begin
      Ei_barra = 0; Lm_barra = 0; tick();
      CE_barra = 0; Lb_barra = 0; tick();
      Eu = 1; Su = (op == 4'h2); La_barra = 0; tick();
    end else if (op == 4'hE) begin
      Ea = 1; Lo_barra = 0; tick();
      tick();
      tick();
    end else begin
      tick(); tick(); tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ri, saida, halted, bus_err} !== 14'h0) begin
      failures++;
      $display("FAIL reset_initial got ri=%h saida=%h halted=%b bus_err=%b want all 0", ri, saida, halted, bus_err);
    end
    load_via_ram(4'h0, 8'h5A, 2);
    CE_barra = 0; Li_barra = 0; La_barra = 0; tick();
    Ea = 1; Eu = 1; tick();
    checks++;
    if (saida !== 8'h5A || ri !== 4'h5 || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload got saida=%h ri=%h bus_err=%b want 5a 5 1", saida, ri, bus_err);
    end
    #2 clr = 1;
    #1;
    checks++;
    if ({ri, saida, halted, bus_err} !== 14'h0) begin
      failures++;
      $display("FAIL reset_async got ri=%h saida=%h halted=%b bus_err=%b want all 0", ri, saida, halted, bus_err);
    end
    #1 clr = 0;
    CE_barra = 0; Lo_barra = 0; tick();
    checks++;
    if (saida !== 8'h5A) begin
      failures++;
      $display("FAIL reset_ram_kept got %h want 5a", saida);
    end
  endtask

  task automatic test_full_program();
    logic [7:0] prog [5];
    prog = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0};
    pulse_clr();
    for (int i = 0; i < 5; i++) prog_write(i[3:0], prog[i]);
    prog_write(4'h9, 8'h10);
    prog_write(4'hA, 8'h14);
    prog_write(4'hB, 8'h18);
    for (int i = 0; i < 4; i++) run_instr();
    checks++;
    if (saida !== 8'h0C || halted !== 1'b0) begin
      failures++;
      $display("FAIL full_prog_out got saida=%h halted=%b want 0c 0", saida, halted);
    end
    run_instr();
    checks++;
    if (halted !== 1'b1 || dut.pc !== 4'h5 || ri !== 4'hF) begin
      failures++;
      $display("FAIL full_prog_halt got halted=%b pc=%h ri=%h want 1 5 f", halted, dut.pc, ri);
    end
  endtask

  task automatic test_halt_write();
    Cp = 1; Ep = 1; Lo_barra = 0; tick();
    Cp = 1; CE_barra = 0; La_barra = 0; Li_barra = 0; tick();
    checks++;
    if (saida !== 8'h0C || dut.pc !== 4'h5 || halted !== 1'b1 || ri !== 4'hF) begin
      failures++;
      $display("FAIL halt_frozen got saida=%h pc=%h halted=%b ri=%h want 0c 5 1 f", saida, dut.pc, halted, ri);
    end
    prog_write(4'h7, 8'hAB);
    pulse_clr();
    checks++;
    if (halted !== 1'b0 || saida !== 8'h00) begin
      failures++;
      $display("FAIL halt_clr got halted=%b saida=%h want 0 00", halted, saida);
    end
    load_via_ram(4'h0, 8'h07, 3);
    CE_barra = 0; Lo_barra = 0; tick();
    checks++;
    if (saida !== 8'hAB) begin
      failures++;
      $display("FAIL halt_prog_write got %h want ab", saida);
    end
  endtask

  task automatic test_wrap();
    pulse_clr();
    prog_write(4'h0, 8'h09);
    prog_write(4'h1, 8'h2A);
    prog_write(4'h2, 8'hE0);
    prog_write(4'h3, 8'hF0);
    prog_write(4'h9, 8'h03);
    prog_write(4'hA, 8'h05);
    for (int i = 0; i < 4; i++) run_instr();
    checks++;
    if (saida !== 8'hFE || halted !== 1'b1) begin
      failures++;
      $display("FAIL sub_wrap got saida=%h halted=%b want fe 1", saida, halted);
    end
    pulse_clr();
    for (int i = 0; i < 15; i++) begin
      Cp = 1; tick();
    end
    Ep = 1; Lo_barra = 0; tick();
    checks++;
    if (saida !== 8'h0F) begin
      failures++;
      $display("FAIL pc_at_15 got %h want 0f", saida);
    end
    Cp = 1; tick();
    Ep = 1; Lo_barra = 0; tick();
    checks++;
    if (saida !== 8'h00) begin
      failures++;
      $display("FAIL pc_wrap got %h want 00", saida);
    end
  endtask

  task automatic test_bus_fault();
    pulse_clr();
    load_via_ram(4'h0, 8'h55, 0);
    for (int i = 0; i < 3; i++) begin
      Cp = 1; tick();
    end
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL bus_err_clean got %b want 0", bus_err);
    end
    Ep = 1; Ea = 1; La_barra = 0; tick();
    checks++;
    if (bus_err !== 1'b1) begin
      failures++;
      $display("FAIL bus_err_set got %b want 1", bus_err);
    end
    Ea = 1; Lo_barra = 0; tick();
    tick(); tick(); tick();
    checks++;
    if (saida !== 8'h03 || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL bus_err_sticky got saida=%h bus_err=%b want 03 1", saida, bus_err);
    end
    pulse_clr();
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL bus_err_clr got %b want 0", bus_err);
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] want;
    pulse_clr();
    load_via_ram(4'h0, 8'h10, 0);
    load_via_ram(4'h0, 8'h01, 1);
    want = 8'h10;
    for (int i = 0; i < 3; i++) begin
      Eu = 1; La_barra = 0; Lo_barra = 0; tick();
      want = want + 8'h01;
      checks++;
      if (saida !== want || bus_err !== 1'b0) begin
        failures++;
        $display("FAIL same_edge_%0d got saida=%h bus_err=%b want %h 0", i, saida, bus_err, want);
      end
    end
  endtask

  task automatic test_random_bus();
    logic [7:0] av, bv, want, vals [5];
    logic [4:0] sel;
    logic       su, want_err;
    for (int it = 0; it < 16; it++) begin
      pulse_clr();
      av  = 8'($urandom);
      bv  = 8'($urandom);
      sel = 5'($urandom);
      su  = 1'($urandom);
      load_via_ram(4'h0, av, 0);
      load_via_ram(4'h0, bv, 1);
      // index 0 is the highest-priority source: PC, RAM[0], IR nibble, ACC, ALU
      vals[0] = 8'h00;
      vals[1] = bv;
      vals[2] = 8'h00;
      vals[3] = av;
      vals[4] = su ? av - bv : av + bv;
      want = 8'h00;
      for (int k = 4; k >= 0; k--) if (sel[k]) want = vals[k];
      want_err = ($countones(sel) >= 2);
      Ep = sel[0]; CE_barra = !sel[1]; Ei_barra = !sel[2]; Ea = sel[3]; Eu = sel[4]; Su = su;
      Lo_barra = 0;
      tick();
      checks++;
      if (saida !== want || bus_err !== want_err) begin
        failures++;
        $display("FAIL rand_bus_%0d sel=%b got saida=%h bus_err=%b want %h %b", it, sel, saida, bus_err, want, want_err);
      end
    end
  endtask

  task automatic test_random_programs();
    logic [7:0] m [16];
    logic [7:0] macc, mout, instr;
    logic [3:0] op, a;
    logic       mhalt;
    for (int it = 0; it < 8; it++) begin
      pulse_clr();
      for (int i = 0; i < 7; i++) begin
        case ($urandom_range(0, 4))
          0: op = 4'h0;
          1: op = 4'h1;
          2: op = 4'h2;
          3: op = 4'hE;
          default: op = 4'($urandom_range(3, 13));
        endcase
        if (i == 0) op = 4'h0;
        m[i] = {op, 4'($urandom_range(0, 15))};
      end
      m[7] = 8'hF0;
      for (int i = 8; i < 16; i++) m[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) prog_write(i[3:0], m[i]);
      macc = 0; mout = 0; mhalt = 0;
      for (int s = 0; s < 8; s++) begin
        run_instr();
        instr = m[s];
        op = instr[7:4];
        a  = instr[3:0];
        case (op)
          4'h0: macc = m[a];
          4'h1: macc = macc + m[a];
          4'h2: macc = macc - m[a];
          4'hE: mout = macc;
          4'hF: mhalt = 1;
          default: ;
        endcase
        checks++;
        if (saida !== mout || ri !== op || halted !== mhalt) begin
          failures++;
          $display("FAIL rand_prog_%0d_step%0d got saida=%h ri=%h halted=%b want %h %h %b", it, s, saida, ri, halted, mout, op, mhalt);
        end
      end
    end
  endtask

  initial begin
    idle();
    prog_addr = 0;
    prog_data = 0;
    clr = 1;
    #1;
    test_reset_wrapper();
  end

  task automatic test_reset_wrapper();
    #6 clr = 0;
    test_reset();
    test_full_program();
    test_halt_write();
    test_wrap();
    test_bus_fault();
    test_same_edge();
    test_random_bus();
    test_random_programs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

endmodule
